// File: rtl/conv2d_kernel3x3.sv
// ============================================================================
// Module      : conv2d_kernel3x3
// Description : Streaming 3x3 convolution (Gaussian / Sobel gx,gy / Sobel
//               magnitude / passthrough) with line buffers and valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv2d_kernel3x3 #(
  parameter int WIDTH_P  = 8,
  parameter int DEPTH_P  = 16,
  parameter int HEIGHT_P = 16
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [WIDTH_P-1:0]          data_i,
  input  logic [1:0]                  mode_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic signed [2*WIDTH_P-1:0] gx_o,
  output logic signed [2*WIDTH_P-1:0] gy_o,
  output logic                        last_o
);

  localparam int c_CW = $clog2(DEPTH_P);
  localparam int c_RW = $clog2(HEIGHT_P);
  localparam int c_OW = 2 * WIDTH_P;
  // Internal arithmetic width: wide enough for the Gaussian sum and signed Sobel terms.
  localparam int c_SW = 2 * WIDTH_P + 2;

  localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(DEPTH_P - 1);
  localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(HEIGHT_P - 1);
  localparam logic [c_SW-1:0] c_PIX_MAX  = {{(c_SW-WIDTH_P){1'b0}}, {WIDTH_P{1'b1}}};

  localparam logic [1:0] c_MODE_GAUSS = 2'd0;
  localparam logic [1:0] c_MODE_SOBEL = 2'd1;
  localparam logic [1:0] c_MODE_MAG   = 2'd2;

  logic                w_advance;
  logic                w_accept;
  logic                w_interior;
  logic                w_frame_start;
  logic                w_frame_end;

  logic [c_CW-1:0]     r_col;
  logic [c_RW-1:0]     r_row;
  logic [1:0]          r_mode;

  logic [WIDTH_P-1:0]  r_lb1 [DEPTH_P];
  logic [WIDTH_P-1:0]  r_lb2 [DEPTH_P];
  logic [WIDTH_P-1:0]  w_above;
  logic [WIDTH_P-1:0]  w_above2;

  logic [WIDTH_P-1:0]  r_win [3][3];

  logic                r_s1_valid;
  logic                r_s1_last;
  logic [1:0]          r_s1_mode;

  logic signed [c_SW-1:0] w_p [3][3];
  logic signed [c_SW-1:0] w_gsum;
  logic signed [c_SW-1:0] w_gx;
  logic signed [c_SW-1:0] w_gy;
  logic        [c_SW-1:0] w_agx;
  logic        [c_SW-1:0] w_agy;
  logic        [c_SW-1:0] w_mag;
  logic [WIDTH_P-1:0]     w_blur;
  logic [WIDTH_P-1:0]     w_sat;
  logic [c_OW-1:0]        w_res_a;
  logic [c_OW-1:0]        w_res_b;

  assign w_advance     = ready_i | ~valid_o;
  assign ready_o       = w_advance;
  assign w_accept      = valid_i & w_advance;
  assign w_interior    = (r_row >= c_RW'(2)) && (r_col >= c_CW'(2));
  assign w_frame_start = (r_row == '0) && (r_col == '0);
  assign w_frame_end   = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);

  // Raster position of the pixel offered on data_i.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (r_col == c_COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + c_RW'(1);
      end else begin
        r_col <= r_col + c_CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_mode <= c_MODE_GAUSS;
    end else if (w_accept && w_frame_start) begin
      r_mode <= mode_i;
    end
  end

  assign w_above  = r_lb1[r_col];
  assign w_above2 = r_lb2[r_col];

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_lb1[r_col] <= data_i;
      r_lb2[r_col] <= w_above;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= w_above2;
      r_win[1][2] <= w_above;
      r_win[2][2] <= data_i;
    end
  end

  // The mode travels with the result so a new frame's mode cannot affect the previous frame's last result.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_mode  <= c_MODE_GAUSS;
    end else if (w_advance) begin
      r_s1_valid <= w_accept & w_interior;
      r_s1_last  <= w_accept & w_interior & w_frame_end;
      r_s1_mode  <= r_mode;
    end
  end

  for (genvar gr = 0; gr < 3; gr++) begin : g_win_row
    for (genvar gc = 0; gc < 3; gc++) begin : g_win_col
      assign w_p[gr][gc] = {{(c_SW-WIDTH_P){1'b0}}, r_win[gr][gc]};
    end
  end

  always_comb begin
    w_gsum = w_p[0][0] + (w_p[0][1] <<< 1) + w_p[0][2]
           + (w_p[1][0] <<< 1) + (w_p[1][1] <<< 2) + (w_p[1][2] <<< 1)
           + w_p[2][0] + (w_p[2][1] <<< 1) + w_p[2][2];
    w_gx   = (w_p[0][2] + (w_p[1][2] <<< 1) + w_p[2][2])
           - (w_p[0][0] + (w_p[1][0] <<< 1) + w_p[2][0]);
    w_gy   = (w_p[2][0] + (w_p[2][1] <<< 1) + w_p[2][2])
           - (w_p[0][0] + (w_p[0][1] <<< 1) + w_p[0][2]);
    w_agx  = w_gx[c_SW-1] ? -w_gx : w_gx;
    w_agy  = w_gy[c_SW-1] ? -w_gy : w_gy;
    w_mag  = w_agx + w_agy;
    w_blur = WIDTH_P'(w_gsum >>> 4);
    w_sat  = (w_mag > c_PIX_MAX) ? {WIDTH_P{1'b1}} : WIDTH_P'(w_mag);
  end

  always_comb begin
    w_res_a = {{WIDTH_P{1'b0}}, r_win[1][1]};
    w_res_b = {{WIDTH_P{1'b0}}, r_win[1][1]};
    case (r_s1_mode)
      c_MODE_GAUSS: begin
        w_res_a = {{WIDTH_P{1'b0}}, w_blur};
        w_res_b = {{WIDTH_P{1'b0}}, w_blur};
      end
      c_MODE_SOBEL: begin
        w_res_a = c_OW'(w_gx);
        w_res_b = c_OW'(w_gy);
      end
      c_MODE_MAG: begin
        w_res_a = {{WIDTH_P{1'b0}}, w_sat};
        w_res_b = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      gx_o    <= '0;
      gy_o    <= '0;
    end else if (w_advance) begin
      valid_o <= r_s1_valid;
      last_o  <= r_s1_valid & r_s1_last;
      if (r_s1_valid) begin
        gx_o <= w_res_a;
        gy_o <= w_res_b;
      end
    end
  end

endmodule

`default_nettype wire
